// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD controller and its datapath bench.
package gcd_pkg;

   localparam int unsigned MAX_ITER_DEF = 255;
   localparam int unsigned ITER_W_DEF   = 8;
   localparam int unsigned STATE_W      = 4;
   localparam int unsigned CMD_W        = 4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = 4'd0,
      S_LOAD    = 4'd1,
      S_SETTLE  = 4'd2,
      S_COMPARE = 4'd3,
      S_SUB_A   = 4'd4,
      S_SUB_B   = 4'd5,
      S_ASSIGN  = 4'd6,
      S_DONE    = 4'd7,
      S_FAULT   = 4'd8
   } state_e;

   // One-hot datapath command word: {AssignRes, BsubA, AsubB, load}
   typedef logic [CMD_W-1:0] cmd_t;

   localparam cmd_t CMD_NONE   = 4'b0000;
   localparam cmd_t CMD_LOAD   = 4'b0001;
   localparam cmd_t CMD_ASUBB  = 4'b0010;
   localparam cmd_t CMD_BSUBA  = 4'b0100;
   localparam cmd_t CMD_ASSIGN = 4'b1000;

   // Datapath command issued while the FSM sits in a given state
   function automatic cmd_t state_cmd(input state_e s);
      cmd_t c;
      c = CMD_NONE;
      case (s)
         S_LOAD:   c = CMD_LOAD;
         S_SUB_A:  c = CMD_ASUBB;
         S_SUB_B:  c = CMD_BSUBA;
         S_ASSIGN: c = CMD_ASSIGN;
         default:  c = CMD_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/gcd_ctrl_fsm.sv
// GCD control FSM: sequences load/subtract/assign commands for gcd_datapath from its
// registered comparison flags, pulses done, and latches fault on timeout or bad flags.
// Optional feature: define GCD_ITER_COUNT_EN to expose the subtract count as iter_count.
module gcd_ctrl_fsm
   import gcd_pkg::*;
#(
   parameter int unsigned MAX_ITER = MAX_ITER_DEF,
   parameter int unsigned ITER_W   = ITER_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic              load_dp,
   output logic              AsubB_dp,
   output logic              BsubA_dp,
   output logic              AssignRes_dp,
   input  logic              AgtB_dp,
   input  logic              BgtA_dp,
   input  logic              AeqB_dp
`ifdef GCD_ITER_COUNT_EN
   ,
   output logic [ITER_W-1:0] iter_count
`endif
);

   // Elaboration guard: the iteration limit must be representable in the counter
   if (MAX_ITER >= (64'd1 << ITER_W)) begin : g_bad_iter_w
      $error("gcd_ctrl_fsm: MAX_ITER does not fit in ITER_W bits");
   end

   localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

   state_e            state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   cmd_t              cmd_q, cmd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fault_q, fault_d;

   logic [2:0]        flags;
   logic              at_limit;

   assign flags    = {AgtB_dp, BgtA_dp, AeqB_dp};
   assign at_limit = (iter_q == ITER_MAX);

   // Next-state, iteration counter and registered-output decode from the next state
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               iter_d  = '0;
            end
         end
         S_LOAD:   state_d = S_SETTLE;
         S_SETTLE: state_d = S_COMPARE;
         S_COMPARE: begin
            case (flags)
               3'b001:  state_d = S_ASSIGN;
               3'b100:  state_d = at_limit ? S_FAULT : S_SUB_A;
               3'b010:  state_d = at_limit ? S_FAULT : S_SUB_B;
               default: state_d = S_FAULT;
            endcase
         end
         S_SUB_A, S_SUB_B: begin
            state_d = S_SETTLE;
            // Saturating increment; the limit check in COMPARE keeps it from being reached twice
            iter_d  = at_limit ? iter_q : iter_q + ITER_W'(1);
         end
         S_ASSIGN: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         S_FAULT: begin
            if (start) begin
               state_d = S_LOAD;
               iter_d  = '0;
            end
         end
         default:  state_d = S_IDLE;
      endcase

      cmd_d   = state_cmd(state_d);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      fault_d = (state_d == S_FAULT);
   end

   // State, counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         cmd_q   <= CMD_NONE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         cmd_q   <= cmd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign fault        = fault_q;
   assign load_dp      = cmd_q[0];
   assign AsubB_dp     = cmd_q[1];
   assign BsubA_dp     = cmd_q[2];
   assign AssignRes_dp = cmd_q[3];

`ifdef GCD_ITER_COUNT_EN
   // Counter is only cleared by an accepted start, so it holds the last operation's count
   assign iter_count = iter_q;
`endif

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// Directed bench for gcd_ctrl_fsm with a behavioural datapath (registered flags).
// Edge labels: a value sampled at the negedge after posedge k-1 is "at edge k",
// counting from the posedge where start is sampled as edge 0.
module tb_gcd_ctrl_fsm;
   import gcd_pkg::*;

   localparam int unsigned TB_ITER_W   = 8;
   localparam int unsigned TB_MAX_ITER = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done, fault;
   logic load_dp, AsubB_dp, BsubA_dp, AssignRes_dp;
   logic AgtB_dp, BgtA_dp, AeqB_dp;
`ifdef GCD_ITER_COUNT_EN
   logic [TB_ITER_W-1:0] iter_count;
`endif

   // Datapath model
   logic [7:0] op_a = 8'd0, op_b = 8'd0;
   logic [7:0] dp_a = 8'd0, dp_b = 8'd0, dp_res = 8'd0;
   logic       agtb_q = 1'b0, bgta_q = 1'b0, aeqb_q = 1'b0;
   logic       force_both = 1'b0;
   logic [3:0] cmd_obs;

   int n_checks = 0;
   int n_errors = 0;
   int onehot_viol = 0;

   int trace[$];
   int exp_q[$];
   int n_done, done_edge, fault_edge, fault_at1;

   gcd_ctrl_fsm #(
      .MAX_ITER (TB_MAX_ITER),
      .ITER_W   (TB_ITER_W)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .fault        (fault),
      .load_dp      (load_dp),
      .AsubB_dp     (AsubB_dp),
      .BsubA_dp     (BsubA_dp),
      .AssignRes_dp (AssignRes_dp),
      .AgtB_dp      (AgtB_dp),
      .BgtA_dp      (BgtA_dp),
      .AeqB_dp      (AeqB_dp)
`ifdef GCD_ITER_COUNT_EN
      ,
      .iter_count   (iter_count)
`endif
   );

   always #5 clk = ~clk;

   assign cmd_obs = {AssignRes_dp, BsubA_dp, AsubB_dp, load_dp};
   assign AgtB_dp = agtb_q | force_both;
   assign BgtA_dp = bgta_q | force_both;
   assign AeqB_dp = aeqb_q & ~force_both;

   // Behavioural datapath: operand/result registers and registered comparison flags
   always @(posedge clk) begin
      if (load_dp) begin
         dp_a <= op_a;
         dp_b <= op_b;
      end else if (AsubB_dp) begin
         dp_a <= dp_a - dp_b;
      end else if (BsubA_dp) begin
         dp_b <= dp_b - dp_a;
      end
      if (AssignRes_dp) dp_res <= dp_a;
      agtb_q <= (dp_a > dp_b);
      bgta_q <= (dp_b > dp_a);
      aeqb_q <= (dp_a == dp_b);
   end

   always @(negedge clk) begin
      if ($countones(cmd_obs) > 1) onehot_viol++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Start one operation and record the command trace as edge*16 + command bits
   task automatic run_gcd(input logic [7:0] a, input logic [7:0] b,
                          input bit spam, input int budget);
      trace.delete();
      n_done     = 0;
      done_edge  = -1;
      fault_edge = -1;
      fault_at1  = -1;
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         start = spam && (k < 14) && (k % 2 == 0);
         if (k == 1) fault_at1 = int'(fault);
         if (cmd_obs != 4'b0) trace.push_back(k * 16 + int'(cmd_obs));
         if (done) begin
            n_done++;
            if (done_edge < 0) done_edge = k;
         end
         if (fault) begin
            fault_edge = k;
            break;
         end
         if (done_edge >= 0 && k >= done_edge + 3) break;
      end
      start = 1'b0;
   endtask

   task automatic check_trace(input string tag);
      chk({tag, ".len"}, trace.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), trace[i], exp_q[i]);
   endtask

   initial begin
      bit seen_sub;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.busy", int'(busy), 0);
      chk("rst.done", int'(done), 0);
      chk("rst.fault", int'(fault), 0);
      chk("rst.cmd", int'(cmd_obs), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.busy", int'(busy), 0);

      // Equal operands: assign at 4, done at 5
      run_gcd(8'd12, 8'd12, 1'b0, 40);
      exp_q = '{1*16+1, 4*16+8};
      check_trace("eq.trace");
      chk("eq.done_edge", done_edge, 5);
      chk("eq.n_done", n_done, 1);
      chk("eq.fault", fault_edge, -1);
      chk("eq.result", int'(dp_res), 12);
      chk("eq.busy_after", int'(busy), 0);
`ifdef GCD_ITER_COUNT_EN
      chk("eq.iter_count", int'(iter_count), 0);
`endif

      // 48/18: AsubB, AsubB, BsubA, AsubB, assign, done at 17
      run_gcd(8'd48, 8'd18, 1'b0, 60);
      exp_q = '{1*16+1, 4*16+2, 7*16+2, 10*16+4, 13*16+2, 16*16+8};
      check_trace("g48.trace");
      chk("g48.done_edge", done_edge, 17);
      chk("g48.n_done", n_done, 1);
      chk("g48.fault", fault_edge, -1);
      chk("g48.result", int'(dp_res), 6);
`ifdef GCD_ITER_COUNT_EN
      chk("g48.iter_count", int'(iter_count), 4);
`endif

      // Same operation with start pulsed while busy: identical trace, single done
      run_gcd(8'd48, 8'd18, 1'b1, 60);
      check_trace("spam.trace");
      chk("spam.done_edge", done_edge, 17);
      chk("spam.n_done", n_done, 1);
      chk("spam.result", int'(dp_res), 6);

      // Zero operand: four BsubA then timeout fault
      run_gcd(8'd0, 8'd5, 1'b0, 60);
      exp_q = '{1*16+1, 4*16+4, 7*16+4, 10*16+4, 13*16+4};
      check_trace("zero.trace");
      chk("zero.fault_edge", fault_edge, 16);
      chk("zero.n_done", n_done, 0);
`ifdef GCD_ITER_COUNT_EN
      chk("zero.iter_count", int'(iter_count), 4);
`endif
      repeat (3) @(negedge clk);
      chk("zero.fault_held", int'(fault), 1);
      chk("zero.busy_held", int'(busy), 1);
      chk("zero.no_done", int'(done), 0);

      // Start from FAULT clears fault and runs normally
      run_gcd(8'd7, 8'd7, 1'b0, 40);
      chk("clr.fault_at1", fault_at1, 0);
      exp_q = '{1*16+1, 4*16+8};
      check_trace("clr.trace");
      chk("clr.done_edge", done_edge, 5);
      chk("clr.result", int'(dp_res), 7);

      // Reset asserted during SUB_A
      @(negedge clk);
      op_a  = 8'd48;
      op_b  = 8'd18;
      start = 1'b1;
      @(posedge clk);
      seen_sub = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (AsubB_dp) begin
            seen_sub = 1'b1;
            break;
         end
      end
      chk("rstmid.seen_sub", int'(seen_sub), 1);
      rst = 1'b1;
      #1;
      chk("rstmid.cmd", int'(cmd_obs), 0);
      chk("rstmid.busy", int'(busy), 0);
      chk("rstmid.done", int'(done), 0);
      chk("rstmid.fault", int'(fault), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid.idle_busy", int'(busy), 0);
      chk("rstmid.idle_done", int'(done), 0);
      run_gcd(8'd12, 8'd12, 1'b0, 40);
      exp_q = '{1*16+1, 4*16+8};
      check_trace("rerun.trace");
      chk("rerun.done_edge", done_edge, 5);
      chk("rerun.result", int'(dp_res), 12);

      // Contradictory flags in COMPARE: fault at edge 4, no assign
      force_both = 1'b1;
      run_gcd(8'd12, 8'd12, 1'b0, 20);
      exp_q = '{1*16+1};
      check_trace("flags.trace");
      chk("flags.fault_edge", fault_edge, 4);
      chk("flags.n_done", n_done, 0);
      force_both = 1'b0;
      run_gcd(8'd9, 8'd9, 1'b0, 40);
      chk("flags.clr_fault", fault_at1, 0);
      chk("flags.clr_done", done_edge, 5);

      chk("cmd.onehot_viol", onehot_viol, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
